// File: rtl/hazard_scoreboard_if.sv
// Hazard scoreboard bundle: ID/EX pipeline view in, stall/flush controls out.
// Optional macro HAZARD_STATS_EN adds the 32-bit stall_cycles statistic.
interface hazard_scoreboard_if #(
    parameter int REG_ADDR_W = 5
);
    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic                  id_rs1_used;
    logic                  id_rs2_used;
    logic                  ex_valid;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  ex_mem_read;
    logic                  ex_branch_taken;
    logic                  stall;
    logic                  flush_if_id;
    logic                  flush_id_ex;
    logic                  sb_busy;
`ifdef HAZARD_STATS_EN
    logic [31:0]           stall_cycles;
`endif

    // Pipeline side: presents decode/execute state, consumes controls.
    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
        output ex_valid, ex_rd, ex_mem_read, ex_branch_taken,
        input  stall, flush_if_id, flush_id_ex, sb_busy
`ifdef HAZARD_STATS_EN
        , input stall_cycles
`endif
    );

    // Hazard unit side.
    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
        input  ex_valid, ex_rd, ex_mem_read, ex_branch_taken,
        output stall, flush_if_id, flush_id_ex, sb_busy
`ifdef HAZARD_STATS_EN
        , output stall_cycles
`endif
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Load-use hazard and control-flush unit beside the ID stage of a 5-stage
// RISC-V pipeline. Loads leaving EX are tracked in a per-register countdown
// scoreboard so consumers wait out LOAD_LATENCY cycles of memory latency.
// Optional macro HAZARD_STATS_EN builds a 32-bit wrapping stall counter.
module hazard_scoreboard #(
    parameter int REG_ADDR_W   = 5,
    parameter int LOAD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    hazard_scoreboard_if.slave bus
);
    localparam int NUM_REGS = 2 ** REG_ADDR_W;
    localparam int CNT_W    = ($clog2(LOAD_LATENCY + 1) < 1) ? 1 : $clog2(LOAD_LATENCY + 1);

    logic ex_load_s;
    logic ex_hit_rs1_s;
    logic ex_hit_rs2_s;
    logic sb_hit_rs1_s;
    logic sb_hit_rs2_s;
    logic m_rs1_s;
    logic m_rs2_s;
    logic haz_s;
    logic sb_busy_s;
    logic stall_s;
    logic flush_if_id_s;
    logic flush_id_ex_s;
    logic sb_busy_out_s;

    assign ex_load_s    = bus.ex_valid & bus.ex_mem_read;
    assign ex_hit_rs1_s = ex_load_s & (bus.ex_rd == bus.id_rs1);
    assign ex_hit_rs2_s = ex_load_s & (bus.ex_rd == bus.id_rs2);

    generate
        if (LOAD_LATENCY > 1) begin : g_sb
            localparam logic [CNT_W-1:0] ISSUE_VAL = CNT_W'(LOAD_LATENCY - 1);

            // x0 has no entry: index range starts at 1.
            logic [CNT_W-1:0] cnt_r [1:NUM_REGS-1];
            logic             load_issue_s;

            // A load on the wrong path (branch resolving taken) never enters tracking.
            assign load_issue_s = ex_load_s & (bus.ex_rd != '0) & ~bus.ex_branch_taken;

            // Countdown per register; a fresh issue overrides the running decrement.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int r = 1; r < NUM_REGS; r++) begin
                        cnt_r[r] <= '0;
                    end
                end else begin
                    for (int r = 1; r < NUM_REGS; r++) begin
                        if (load_issue_s && (bus.ex_rd == REG_ADDR_W'(r))) begin
                            cnt_r[r] <= ISSUE_VAL;
                        end else if (cnt_r[r] != '0) begin
                            cnt_r[r] <= cnt_r[r] - CNT_W'(1);
                        end else begin
                            cnt_r[r] <= cnt_r[r];
                        end
                    end
                end
            end

            // Look up both sources and summarise occupancy.
            always_comb begin
                sb_busy_s    = 1'b0;
                sb_hit_rs1_s = 1'b0;
                sb_hit_rs2_s = 1'b0;
                for (int r = 1; r < NUM_REGS; r++) begin
                    if (cnt_r[r] != '0) begin
                        sb_busy_s = 1'b1;
                        if (bus.id_rs1 == REG_ADDR_W'(r)) begin
                            sb_hit_rs1_s = 1'b1;
                        end else begin
                            sb_hit_rs1_s = sb_hit_rs1_s;
                        end
                        if (bus.id_rs2 == REG_ADDR_W'(r)) begin
                            sb_hit_rs2_s = 1'b1;
                        end else begin
                            sb_hit_rs2_s = sb_hit_rs2_s;
                        end
                    end else begin
                        sb_busy_s = sb_busy_s;
                    end
                end
            end
        end else begin : g_no_sb
            // Single-cycle latency: the EX comparison alone covers the hazard.
            assign sb_busy_s    = 1'b0;
            assign sb_hit_rs1_s = 1'b0;
            assign sb_hit_rs2_s = 1'b0;
        end
    endgenerate

    assign m_rs1_s = bus.id_rs1_used & (bus.id_rs1 != '0) & (ex_hit_rs1_s | sb_hit_rs1_s);
    assign m_rs2_s = bus.id_rs2_used & (bus.id_rs2 != '0) & (ex_hit_rs2_s | sb_hit_rs2_s);
    assign haz_s   = bus.id_valid & (m_rs1_s | m_rs2_s);

    // Control outputs: reset silences everything, a taken branch beats any stall.
    always_comb begin
        stall_s       = 1'b0;
        flush_if_id_s = 1'b0;
        flush_id_ex_s = 1'b0;
        sb_busy_out_s = 1'b0;
        if (rst) begin
            stall_s       = 1'b0;
            flush_if_id_s = 1'b0;
            flush_id_ex_s = 1'b0;
            sb_busy_out_s = 1'b0;
        end else if (bus.ex_branch_taken) begin
            stall_s       = 1'b0;
            flush_if_id_s = 1'b1;
            flush_id_ex_s = 1'b1;
            sb_busy_out_s = sb_busy_s;
        end else begin
            stall_s       = haz_s;
            flush_if_id_s = 1'b0;
            flush_id_ex_s = haz_s;
            sb_busy_out_s = sb_busy_s;
        end
    end

    assign bus.stall       = stall_s;
    assign bus.flush_if_id = flush_if_id_s;
    assign bus.flush_id_ex = flush_id_ex_s;
    assign bus.sb_busy     = sb_busy_out_s;

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cycles_r;

    // Count every stalled cycle; natural 32-bit wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles_r <= 32'd0;
        end else if (stall_s) begin
            stall_cycles_r <= stall_cycles_r + 32'd1;
        end else begin
            stall_cycles_r <= stall_cycles_r;
        end
    end

    assign bus.stall_cycles = stall_cycles_r;
`endif
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: four instances with LOAD_LATENCY 1..4.
module tb_hazard_scoreboard;
    typedef struct packed {
        logic       id_valid;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic       ex_valid;
        logic [4:0] ex_rd;
        logic       mem_read;
        logic       br;
    } stim_t;

    typedef struct {
        stim_t s;
        logic  es;
        logic  efi;
        logic  efe;
    } vec_t;

    logic       clk;
    logic       rst;
    stim_t      st [4];
    logic [3:0] stall_o;
    logic [3:0] fif_o;
    logic [3:0] fie_o;
    logic [3:0] busy_o;
`ifdef HAZARD_STATS_EN
    logic [31:0] sc_o;
`endif

    int total;
    int passed;
    int nstall;
    vec_t tbl [12];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        hazard_scoreboard_if #(.REG_ADDR_W(5)) bus ();
        assign bus.id_valid        = st[g].id_valid;
        assign bus.id_rs1          = st[g].rs1;
        assign bus.id_rs2          = st[g].rs2;
        assign bus.id_rs1_used     = st[g].u1;
        assign bus.id_rs2_used     = st[g].u2;
        assign bus.ex_valid        = st[g].ex_valid;
        assign bus.ex_rd           = st[g].ex_rd;
        assign bus.ex_mem_read     = st[g].mem_read;
        assign bus.ex_branch_taken = st[g].br;
        assign stall_o[g]          = bus.stall;
        assign fif_o[g]            = bus.flush_if_id;
        assign fie_o[g]            = bus.flush_id_ex;
        assign busy_o[g]           = bus.sb_busy;
`ifdef HAZARD_STATS_EN
        if (g == 1) begin : g_sc
            assign sc_o = bus.stall_cycles;
        end
`endif
        hazard_scoreboard #(.REG_ADDR_W(5), .LOAD_LATENCY(g + 1)) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );
    end

    function automatic stim_t mk(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                                 input logic u1, input logic u2, input logic exv,
                                 input logic [4:0] rd, input logic mr, input logic br);
        stim_t s;
        s.id_valid = v;  s.rs1 = r1; s.rs2 = r2; s.u1 = u1; s.u2 = u2;
        s.ex_valid = exv; s.ex_rd = rd; s.mem_read = mr; s.br = br;
        return s;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_outs(input int i, input string tag, input logic es, input logic efi,
                            input logic efe, input logic eb);
        chk({tag, ".stall"}, {31'd0, stall_o[i]}, {31'd0, es});
        chk({tag, ".flush_if_id"}, {31'd0, fif_o[i]}, {31'd0, efi});
        chk({tag, ".flush_id_ex"}, {31'd0, fie_o[i]}, {31'd0, efe});
        chk({tag, ".sb_busy"}, {31'd0, busy_o[i]}, {31'd0, eb});
    endtask

    // Move to the next drive point (negedge); checks follow 2 time units later.
    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        total  = 0;
        passed = 0;
        nstall = 0;
        for (int i = 0; i < 4; i++) st[i] = '0;

        tbl[0]  = '{mk(1'b1, 5'd1,  5'd2, 1'b1, 1'b1, 1'b0, 5'd0,  1'b0, 1'b0), 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{mk(1'b1, 5'd5,  5'd2, 1'b1, 1'b1, 1'b1, 5'd5,  1'b1, 1'b0), 1'b1, 1'b0, 1'b1};
        tbl[2]  = '{mk(1'b1, 5'd3,  5'd5, 1'b1, 1'b1, 1'b1, 5'd5,  1'b1, 1'b0), 1'b1, 1'b0, 1'b1};
        tbl[3]  = '{mk(1'b1, 5'd5,  5'd2, 1'b0, 1'b1, 1'b1, 5'd5,  1'b1, 1'b0), 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{mk(1'b1, 5'd0,  5'd2, 1'b1, 1'b1, 1'b1, 5'd0,  1'b1, 1'b0), 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{mk(1'b1, 5'd3,  5'd5, 1'b1, 1'b0, 1'b1, 5'd5,  1'b1, 1'b0), 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{mk(1'b1, 5'd5,  5'd5, 1'b1, 1'b1, 1'b0, 5'd5,  1'b1, 1'b0), 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{mk(1'b1, 5'd5,  5'd5, 1'b1, 1'b1, 1'b1, 5'd5,  1'b0, 1'b0), 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{mk(1'b0, 5'd5,  5'd5, 1'b1, 1'b1, 1'b1, 5'd5,  1'b1, 1'b0), 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{mk(1'b1, 5'd5,  5'd5, 1'b1, 1'b1, 1'b1, 5'd5,  1'b1, 1'b1), 1'b0, 1'b1, 1'b1};
        tbl[10] = '{mk(1'b1, 5'd1,  5'd2, 1'b1, 1'b1, 1'b0, 5'd0,  1'b0, 1'b1), 1'b0, 1'b1, 1'b1};
        tbl[11] = '{mk(1'b1, 5'd31, 5'd0, 1'b1, 1'b0, 1'b1, 5'd31, 1'b1, 1'b0), 1'b1, 1'b0, 1'b1};

        // Reset with a hazard present: controls must stay low while rst=1.
        rst   = 1'b1;
        st[0] = tbl[1].s;
        cyc(); #2;
        chk_outs(0, "reset_l1", 1'b0, 1'b0, 1'b0, 1'b0);
        chk_outs(2, "reset_l3", 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef HAZARD_STATS_EN
        chk("reset.stall_cycles", sc_o, 32'd0);
`endif
        cyc();
        rst   = 1'b0;
        st[0] = '0;

        // Combinational vectors on the LOAD_LATENCY=1 instance.
        for (int i = 0; i < 12; i++) begin
            cyc();
            st[0] = tbl[i].s;
            #2;
            chk_outs(0, $sformatf("vec%0d", i), tbl[i].es, tbl[i].efi, tbl[i].efe, 1'b0);
        end

        // LOAD_LATENCY=1: one stall cycle, then the bubble clears it.
        cyc(); st[0] = mk(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0); #2;
        chk_outs(0, "l1_c1", 1'b1, 1'b0, 1'b1, 1'b0);
        cyc(); st[0] = mk(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0); #2;
        chk_outs(0, "l1_c2", 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(); st[0] = '0;

        // LOAD_LATENCY=3: three stall cycles, sb_busy only in cycles 2 and 3.
        cyc(); st[2] = mk(1'b1, 5'd7, 5'd0, 1'b1, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0); #2;
        chk_outs(2, "l3_c1", 1'b1, 1'b0, 1'b1, 1'b0);
        cyc(); st[2] = mk(1'b1, 5'd7, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0); #2;
        chk_outs(2, "l3_c2", 1'b1, 1'b0, 1'b1, 1'b1);
        cyc(); #2;
        chk_outs(2, "l3_c3", 1'b1, 1'b0, 1'b1, 1'b1);
        cyc(); #2;
        chk_outs(2, "l3_c4", 1'b0, 1'b0, 1'b0, 1'b0);

        // Taken branch over a load hazard: flush, no stall, nothing tracked.
        cyc(); st[2] = mk(1'b1, 5'd7, 5'd0, 1'b1, 1'b0, 1'b1, 5'd7, 1'b1, 1'b1); #2;
        chk_outs(2, "br_c1", 1'b0, 1'b1, 1'b1, 1'b0);
        cyc(); st[2] = mk(1'b1, 5'd7, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0); #2;
        chk_outs(2, "br_c2", 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(); st[2] = '0;

        // LOAD_LATENCY=2: three independent load-use pairs, two stalls each.
        for (int p = 0; p < 3; p++) begin
            logic [4:0] r;
            logic       on2;
            r   = (p == 0) ? 5'd1 : ((p == 1) ? 5'd2 : 5'd30);
            on2 = (p == 1);
            cyc();
            st[1] = mk(1'b1, on2 ? 5'd0 : r, on2 ? r : 5'd0, ~on2, on2, 1'b1, r, 1'b1, 1'b0);
            #2; nstall += int'(stall_o[1]);
            chk_outs(1, $sformatf("l2_p%0d_c1", p), 1'b1, 1'b0, 1'b1, 1'b0);
            cyc();
            st[1] = mk(1'b1, on2 ? 5'd0 : r, on2 ? r : 5'd0, ~on2, on2, 1'b0, 5'd0, 1'b0, 1'b0);
            #2; nstall += int'(stall_o[1]);
            chk_outs(1, $sformatf("l2_p%0d_c2", p), 1'b1, 1'b0, 1'b1, 1'b1);
            cyc(); #2; nstall += int'(stall_o[1]);
            chk_outs(1, $sformatf("l2_p%0d_c3", p), 1'b0, 1'b0, 1'b0, 1'b0);
            cyc(); st[1] = '0;
        end
        chk("l2.stall_total", nstall, 32'd6);
`ifdef HAZARD_STATS_EN
        #2;
        chk("l2.stall_cycles", sc_o, 32'd6);
`endif

        // LOAD_LATENCY=4: reset two cycles into the stall wipes tracking at once.
        cyc(); st[3] = mk(1'b1, 5'd0, 5'd9, 1'b0, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0); #2;
        chk_outs(3, "l4_c1", 1'b1, 1'b0, 1'b1, 1'b0);
        cyc(); st[3] = mk(1'b1, 5'd0, 5'd9, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0); #2;
        chk_outs(3, "l4_c2", 1'b1, 1'b0, 1'b1, 1'b1);
        cyc(); rst = 1'b1; #2;
        chk_outs(3, "l4_rst", 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(); rst = 1'b0; #2;
        chk_outs(3, "l4_rel1", 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(); #2;
        chk_outs(3, "l4_rel2", 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef HAZARD_STATS_EN
        chk("post_reset.stall_cycles", sc_o, 32'd0);
`endif
        cyc(); st[3] = '0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
